// File: rtl/bist_multimode_gen_if.sv
// bist_multimode_gen_if: control and stream bundle between the test controller,
// the BIST generator and the datapath under test.
//   enable        controller -> generator, global advance qualifier
//   capture_start controller -> generator, burst request
//   mode          controller -> generator, pattern select (0 LFSR, 1 counter,
//                 2 walking-ones, 3 checkerboard)
//   data_out      generator  -> datapath, current test word
//   valid_out     generator  -> datapath, data_out is new this cycle
//   sync          generator  -> datapath, first word of a burst
//   busy          generator  -> controller, burst in progress
//   done          generator  -> controller, burst finished pulse
//   signature     generator  -> controller, MISR of the last burst
interface bist_multimode_gen_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  enable;
  logic                  capture_start;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  sync;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] signature;

  // Test controller / checker side
  modport master (
    output enable,
    output capture_start,
    output mode,
    input  data_out,
    input  valid_out,
    input  sync,
    input  busy,
    input  done,
    input  signature
  );

  // Generator side
  modport slave (
    input  enable,
    input  capture_start,
    input  mode,
    output data_out,
    output valid_out,
    output sync,
    output busy,
    output done,
    output signature
  );

endinterface

// File: rtl/bist_multimode_gen.sv
// bist_multimode_gen: BIST stimulus engine. Emits bursts of BURST_LEN test words
// (LFSR, counter, walking-ones or checkerboard) after a C2DR-cycle arm delay and
// folds every word into a MISR whose value is published with the done pulse.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, overrides everything
//   bus  bist_multimode_gen_if.slave (control inputs, stream/status outputs)
// All bus outputs are registered.
module bist_multimode_gen #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           C2DR       = 3,
  parameter int unsigned           BURST_LEN  = 16,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(32'h0040_0007),
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED  = DATA_WIDTH'(32'h0000_0001)
) (
  input  logic                 clk,
  input  logic                 rst,
  bist_multimode_gen_if.slave  bus
);

  localparam int unsigned ARM_W     = (C2DR > 1) ? $clog2(C2DR) : 1;
  localparam int unsigned BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned ARM_LAST  = (C2DR == 0) ? 0 : C2DR - 1;
  localparam int unsigned BEAT_LAST = BURST_LEN - 1;
  localparam bit          SKIP_ARM  = (C2DR == 0);

  localparam logic [ARM_W-1:0]      ARM_LAST_V  = ARM_W'(ARM_LAST);
  localparam logic [BEAT_W-1:0]     BEAT_LAST_V = BEAT_W'(BEAT_LAST);
  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [DATA_WIDTH-1:0] SEED_EFF    =
    (LFSR_SEED == '0) ? DATA_WIDTH'(1) : LFSR_SEED;
  localparam logic [DATA_WIDTH-1:0] CB_START    =
    DATA_WIDTH'({DATA_WIDTH{2'b01}});

  localparam logic [1:0] MODE_LFSR = 2'd0;
  localparam logic [1:0] MODE_CNT  = 2'd1;
  localparam logic [1:0] MODE_WALK = 2'd2;
  localparam logic [1:0] MODE_CB   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] pat_q, pat_d;
  logic [DATA_WIDTH-1:0] misr_q, misr_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [ARM_W-1:0]      arm_q, arm_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] sig_q, sig_d;
  logic                  valid_q, valid_d;
  logic                  sync_q, sync_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic start_c;
  logic restart_c;
  logic arm_last_c;
  logic beat_last_c;

  // Galois shift shared by the LFSR pattern and the MISR.
  function automatic logic [DATA_WIDTH-1:0] galois_step(
    input logic [DATA_WIDTH-1:0] s
  );
    galois_step = {s[DATA_WIDTH-2:0], 1'b0} ^ (s[DATA_WIDTH-1] ? LFSR_TAPS : '0);
  endfunction

  // First word of a burst for the given mode.
  function automatic logic [DATA_WIDTH-1:0] pat_start(input logic [1:0] m);
    unique case (m)
      MODE_LFSR: pat_start = SEED_EFF;
      MODE_CNT:  pat_start = '0;
      MODE_WALK: pat_start = DATA_WIDTH'(1);
      default:   pat_start = CB_START;
    endcase
  endfunction

  // Word following p in the given mode.
  function automatic logic [DATA_WIDTH-1:0] pat_next(
    input logic [DATA_WIDTH-1:0] p,
    input logic [1:0]            m
  );
    unique case (m)
      MODE_LFSR: pat_next = galois_step(p);
      MODE_CNT:  pat_next = p + DATA_WIDTH'(1);
      MODE_WALK: pat_next = {p[DATA_WIDTH-2:0], p[DATA_WIDTH-1]};
      default:   pat_next = ~p;
    endcase
  endfunction

  assign start_c     = bus.enable & bus.capture_start;
  assign arm_last_c  = (arm_q == ARM_LAST_V);
  assign beat_last_c = (beat_q == BEAT_LAST_V);
  // A burst may only be launched from IDLE or at the burst boundary.
  assign restart_c   = start_c & ((state_q == S_IDLE) | (state_q == S_DONE));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_c) begin
          state_d = SKIP_ARM ? S_RUN : S_ARM;
        end
      end
      S_ARM: begin
        if (bus.enable && arm_last_c) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.enable && beat_last_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start_c) begin
          state_d = SKIP_ARM ? S_RUN : S_ARM;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next-values
  always_comb begin
    mode_d  = mode_q;
    pat_d   = pat_q;
    misr_d  = misr_q;
    beat_d  = beat_q;
    arm_d   = arm_q;
    data_d  = data_q;
    sig_d   = sig_q;
    valid_d = 1'b0;
    sync_d  = 1'b0;
    done_d  = 1'b0;
    // busy follows the state being entered so it drops in the done cycle
    // only when the engine returns to IDLE.
    busy_d  = (state_d != S_IDLE);

    unique case (state_q)
      S_ARM: begin
        if (bus.enable) begin
          arm_d = arm_q + ARM_W'(1);
        end
      end
      S_RUN: begin
        if (bus.enable) begin
          valid_d = 1'b1;
          data_d  = pat_q;
          sync_d  = (beat_q == '0);
          misr_d  = galois_step(misr_q) ^ pat_q;
          pat_d   = pat_next(pat_q, mode_q);
          beat_d  = beat_q + BEAT_W'(1);
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        sig_d  = misr_q;
      end
      default: begin
      end
    endcase

    // Burst launch: relatch mode and restart patterns and MISR.
    if (restart_c) begin
      mode_d = bus.mode;
      pat_d  = pat_start(bus.mode);
      misr_d = '0;
      beat_d = '0;
      arm_d  = '0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= '0;
      pat_q   <= '0;
      misr_q  <= '0;
      beat_q  <= '0;
      arm_q   <= '0;
      data_q  <= '0;
      sig_q   <= '0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      misr_q  <= misr_d;
      beat_q  <= beat_d;
      arm_q   <= arm_d;
      data_q  <= data_d;
      sig_q   <= sig_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.sync      = sync_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.signature = sig_q;

`ifndef SYNTHESIS
  // Output relationships that must always hold.
  a_sync_with_valid : assert property (@(posedge clk) disable iff (rst)
    sync_q |-> valid_q);
  a_done_not_valid  : assert property (@(posedge clk) disable iff (rst)
    done_q |-> !valid_q);
  a_valid_busy      : assert property (@(posedge clk) disable iff (rst)
    valid_q |-> busy_q);
`endif

endmodule

// File: tb/tb_bist_multimode_gen.sv
module tb_bist_multimode_gen;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] TAPS = 32'h0040_0007;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en;
  logic       cap;
  logic [1:0] mode;
  logic [1:0] sel;

  bist_multimode_gen_if #(.DATA_WIDTH(W)) bus_a ();
  bist_multimode_gen_if #(.DATA_WIDTH(W)) bus_b ();
  bist_multimode_gen_if #(.DATA_WIDTH(W)) bus_c ();

  // Only the selected engine sees enable/capture; the others stay idle.
  assign bus_a.enable        = en  & (sel == 2'd0);
  assign bus_a.capture_start = cap & (sel == 2'd0);
  assign bus_a.mode          = mode;
  assign bus_b.enable        = en  & (sel == 2'd1);
  assign bus_b.capture_start = cap & (sel == 2'd1);
  assign bus_b.mode          = mode;
  assign bus_c.enable        = en  & (sel == 2'd2);
  assign bus_c.capture_start = cap & (sel == 2'd2);
  assign bus_c.mode          = mode;

  // A: C2DR=3, BURST_LEN=4, seed 1
  bist_multimode_gen #(.DATA_WIDTH(W), .C2DR(3), .BURST_LEN(4),
                       .LFSR_TAPS(TAPS), .LFSR_SEED(32'h0000_0001))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  // B: C2DR=0 (no ARM), BURST_LEN=3, seed 0x80000000
  bist_multimode_gen #(.DATA_WIDTH(W), .C2DR(0), .BURST_LEN(3),
                       .LFSR_TAPS(TAPS), .LFSR_SEED(32'h8000_0000))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  // C: C2DR=1, BURST_LEN=34, seed 0 (promoted to 1)
  bist_multimode_gen #(.DATA_WIDTH(W), .C2DR(1), .BURST_LEN(34),
                       .LFSR_TAPS(TAPS), .LFSR_SEED(32'h0000_0000))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

  logic [W-1:0] o_data, o_sig;
  logic         o_valid, o_sync, o_busy, o_done;

  always_comb begin
    case (sel)
      2'd1: begin
        o_data = bus_b.data_out; o_sig = bus_b.signature; o_valid = bus_b.valid_out;
        o_sync = bus_b.sync; o_busy = bus_b.busy; o_done = bus_b.done;
      end
      2'd2: begin
        o_data = bus_c.data_out; o_sig = bus_c.signature; o_valid = bus_c.valid_out;
        o_sync = bus_c.sync; o_busy = bus_c.busy; o_done = bus_c.done;
      end
      default: begin
        o_data = bus_a.data_out; o_sig = bus_a.signature; o_valid = bus_a.valid_out;
        o_sync = bus_a.sync; o_busy = bus_a.busy; o_done = bus_a.done;
      end
    endcase
  end

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  bit           sync_q[$];

  function automatic logic [W-1:0] galois(input logic [W-1:0] s);
    return (s << 1) ^ (s[W-1] ? TAPS : 32'h0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    en  = 1'b0;
    cap = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    sel = 2'd0;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (o_data !== 32'h0)  begin failures++; $display("FAIL rst_data got=%h exp=0", o_data); end
    checks++; if (o_valid !== 1'b0)  begin failures++; $display("FAIL rst_valid got=%b exp=0", o_valid); end
    checks++; if (o_sync !== 1'b0)   begin failures++; $display("FAIL rst_sync got=%b exp=0", o_sync); end
    checks++; if (o_busy !== 1'b0)   begin failures++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
    checks++; if (o_done !== 1'b0)   begin failures++; $display("FAIL rst_done got=%b exp=0", o_done); end
    checks++; if (o_sig !== 32'h0)   begin failures++; $display("FAIL rst_sig got=%h exp=0", o_sig); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_reset_mid_run();
    sel = 2'd0; mode = 2'd1; en = 1'b1; cap = 1'b1;
    tick();
    cap = 1'b0;
    repeat (6) tick();
    checks++; if (o_valid !== 1'b1 || o_data !== 32'd2) begin
      failures++; $display("FAIL midrst_beat2 got v=%b d=%h exp v=1 d=2", o_valid, o_data);
    end
    rst = 1'b1;
    tick();
    checks++; if (o_data !== 32'h0)  begin failures++; $display("FAIL midrst_data got=%h exp=0", o_data); end
    checks++; if (o_valid !== 1'b0)  begin failures++; $display("FAIL midrst_valid got=%b exp=0", o_valid); end
    checks++; if (o_sync !== 1'b0)   begin failures++; $display("FAIL midrst_sync got=%b exp=0", o_sync); end
    checks++; if (o_busy !== 1'b0)   begin failures++; $display("FAIL midrst_busy got=%b exp=0", o_busy); end
    checks++; if (o_done !== 1'b0)   begin failures++; $display("FAIL midrst_done got=%b exp=0", o_done); end
    checks++; if (o_sig !== 32'h0)   begin failures++; $display("FAIL midrst_sig got=%h exp=0", o_sig); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
        failures++; $display("FAIL postrst_quiet k=%0d got v=%b b=%b exp 0 0", k, o_valid, o_busy);
      end
    end
    idle(1);
  endtask

  task automatic test_counter();
    logic [W-1:0] ew;
    bit           es;
    logic         ev;
    sel = 2'd0; mode = 2'd1;
    exp_q.delete(); sync_q.delete();
    for (int i = 0; i < 4; i++) begin exp_q.push_back(W'(i)); sync_q.push_back(i == 0); end
    en = 1'b1; cap = 1'b1;
    tick();
    cap = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      ev = (k >= 4 && k <= 7);
      checks++; if (o_valid !== ev) begin failures++; $display("FAIL cnt_valid k=%0d got=%b exp=%b", k, o_valid, ev); end
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL cnt_extra k=%0d got=%h exp=none", k, o_data);
        end else begin
          ew = exp_q.pop_front(); es = sync_q.pop_front();
          checks++; if (o_data !== ew) begin failures++; $display("FAIL cnt_data k=%0d got=%h exp=%h", k, o_data, ew); end
          checks++; if (o_sync !== es) begin failures++; $display("FAIL cnt_sync k=%0d got=%b exp=%b", k, o_sync, es); end
        end
      end
      checks++; if (o_done !== (k == 8)) begin failures++; $display("FAIL cnt_done k=%0d got=%b exp=%b", k, o_done, k == 8); end
      checks++; if (o_busy !== (k <= 7)) begin failures++; $display("FAIL cnt_busy k=%0d got=%b exp=%b", k, o_busy, k <= 7); end
      if (k == 8) begin
        checks++; if (o_sig !== 32'h3) begin failures++; $display("FAIL cnt_sig got=%h exp=00000003", o_sig); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL cnt_missing got=%0d left exp=0", exp_q.size()); end
    idle(2);
  endtask

  task automatic test_lfsr_no_arm();
    logic [W-1:0] ew, sig;
    bit           es;
    logic         ev;
    sel = 2'd1; mode = 2'd0;
    exp_q.delete(); sync_q.delete();
    exp_q.push_back(32'h8000_0000); exp_q.push_back(32'h0040_0007); exp_q.push_back(32'h0080_000E);
    sync_q.push_back(1'b1); sync_q.push_back(1'b0); sync_q.push_back(1'b0);
    sig = 32'h0;
    for (int i = 0; i < 3; i++) sig = galois(sig) ^ exp_q[i];
    en = 1'b1; cap = 1'b1;
    tick();
    cap = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      ev = (k >= 1 && k <= 3);
      checks++; if (o_valid !== ev) begin failures++; $display("FAIL lfsr_valid k=%0d got=%b exp=%b", k, o_valid, ev); end
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL lfsr_extra k=%0d got=%h exp=none", k, o_data);
        end else begin
          ew = exp_q.pop_front(); es = sync_q.pop_front();
          checks++; if (o_data !== ew) begin failures++; $display("FAIL lfsr_data k=%0d got=%h exp=%h", k, o_data, ew); end
          checks++; if (o_sync !== es) begin failures++; $display("FAIL lfsr_sync k=%0d got=%b exp=%b", k, o_sync, es); end
        end
      end
      checks++; if (o_done !== (k == 4)) begin failures++; $display("FAIL lfsr_done k=%0d got=%b exp=%b", k, o_done, k == 4); end
      if (k == 4) begin
        checks++; if (o_sig !== sig) begin failures++; $display("FAIL lfsr_sig got=%h exp=%h", o_sig, sig); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL lfsr_missing got=%0d left exp=0", exp_q.size()); end
    idle(2);
  endtask

  task automatic test_wide_bursts();
    logic [W-1:0] s, ew;
    bit           es;
    logic         ev;
    sel = 2'd2;
    for (int m = 0; m < 2; m++) begin
      exp_q.delete(); sync_q.delete();
      s = 32'h1;
      for (int i = 0; i < 34; i++) begin
        if (m == 0) begin exp_q.push_back(s); s = galois(s); end
        else exp_q.push_back(W'(1) << (i % W));
        sync_q.push_back(i == 0);
      end
      mode = (m == 0) ? 2'd0 : 2'd2;
      en = 1'b1; cap = 1'b1;
      tick();
      cap = 1'b0;
      for (int k = 1; k <= 37; k++) begin
        tick();
        ev = (k >= 2 && k <= 35);
        checks++; if (o_valid !== ev) begin failures++; $display("FAIL wide_valid m=%0d k=%0d got=%b exp=%b", m, k, o_valid, ev); end
        if (o_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++; failures++; $display("FAIL wide_extra m=%0d k=%0d got=%h exp=none", m, k, o_data);
          end else begin
            ew = exp_q.pop_front(); es = sync_q.pop_front();
            checks++; if (o_data !== ew) begin failures++; $display("FAIL wide_data m=%0d word=%0d got=%h exp=%h", m, k - 2, o_data, ew); end
            checks++; if (o_sync !== es) begin failures++; $display("FAIL wide_sync m=%0d word=%0d got=%b exp=%b", m, k - 2, o_sync, es); end
          end
        end
        checks++; if (o_done !== (k == 36)) begin failures++; $display("FAIL wide_done m=%0d k=%0d got=%b exp=%b", m, k, o_done, k == 36); end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wide_missing m=%0d got=%0d left exp=0", m, exp_q.size()); end
      idle(2);
    end
  endtask

  task automatic test_enable_gaps();
    logic [W-1:0] ew, sig;
    bit           es;
    logic         ev;
    sel = 2'd0; mode = 2'd3;
    exp_q.delete(); sync_q.delete();
    exp_q.push_back(32'h5555_5555); exp_q.push_back(32'hAAAA_AAAA);
    exp_q.push_back(32'h5555_5555); exp_q.push_back(32'hAAAA_AAAA);
    sync_q.push_back(1'b1); sync_q.push_back(1'b0); sync_q.push_back(1'b0); sync_q.push_back(1'b0);
    sig = 32'h0;
    for (int i = 0; i < 4; i++) sig = galois(sig) ^ exp_q[i];
    en = 1'b1; cap = 1'b1;
    tick();
    cap = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      en   = (k == 1 || k == 2 || k == 8) ? 1'b0 : 1'b1;
      mode = 2'(k);
      tick();
      ev = (k == 6 || k == 7 || k == 9 || k == 10);
      checks++; if (o_valid !== ev) begin failures++; $display("FAIL gap_valid k=%0d got=%b exp=%b", k, o_valid, ev); end
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL gap_extra k=%0d got=%h exp=none", k, o_data);
        end else begin
          ew = exp_q.pop_front(); es = sync_q.pop_front();
          checks++; if (o_data !== ew) begin failures++; $display("FAIL gap_data k=%0d got=%h exp=%h", k, o_data, ew); end
          checks++; if (o_sync !== es) begin failures++; $display("FAIL gap_sync k=%0d got=%b exp=%b", k, o_sync, es); end
        end
      end
      if (k == 8) begin
        checks++; if (o_data !== 32'hAAAA_AAAA) begin failures++; $display("FAIL gap_hold got=%h exp=aaaaaaaa", o_data); end
        checks++; if (o_sync !== 1'b0) begin failures++; $display("FAIL gap_sync_hold got=%b exp=0", o_sync); end
      end
      checks++; if (o_busy !== (k <= 10)) begin failures++; $display("FAIL gap_busy k=%0d got=%b exp=%b", k, o_busy, k <= 10); end
      checks++; if (o_done !== (k == 11)) begin failures++; $display("FAIL gap_done k=%0d got=%b exp=%b", k, o_done, k == 11); end
      if (k == 11) begin
        checks++; if (o_sig !== sig) begin failures++; $display("FAIL gap_sig got=%h exp=%h", o_sig, sig); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL gap_missing got=%0d left exp=0", exp_q.size()); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ew;
    bit           es;
    logic         ev;
    sel = 2'd0; mode = 2'd1;
    exp_q.delete(); sync_q.delete();
    for (int i = 0; i < 8; i++) begin exp_q.push_back(W'(i % 4)); sync_q.push_back((i % 4) == 0); end
    en = 1'b1; cap = 1'b1;
    tick();
    for (int k = 1; k <= 18; k++) begin
      cap = (k < 16) ? 1'b1 : 1'b0;
      tick();
      ev = (k >= 4 && k <= 7) || (k >= 12 && k <= 15);
      checks++; if (o_valid !== ev) begin failures++; $display("FAIL b2b_valid k=%0d got=%b exp=%b", k, o_valid, ev); end
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL b2b_extra k=%0d got=%h exp=none", k, o_data);
        end else begin
          ew = exp_q.pop_front(); es = sync_q.pop_front();
          checks++; if (o_data !== ew) begin failures++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, o_data, ew); end
          checks++; if (o_sync !== es) begin failures++; $display("FAIL b2b_sync k=%0d got=%b exp=%b", k, o_sync, es); end
        end
      end
      checks++; if (o_done !== (k == 8 || k == 16)) begin failures++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, o_done, k == 8 || k == 16); end
      checks++; if (o_busy !== (k <= 15)) begin failures++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, o_busy, k <= 15); end
      if ((k >= 8 && k <= 11) || k == 16) begin
        checks++; if (o_sig !== 32'h3) begin failures++; $display("FAIL b2b_sig k=%0d got=%h exp=00000003", k, o_sig); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_missing got=%0d left exp=0", exp_q.size()); end
    idle(2);
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    cap  = 1'b0;
    mode = 2'd0;
    sel  = 2'd0;
    test_reset();
    test_counter();
    test_reset_mid_run();
    test_lfsr_no_arm();
    test_wide_bursts();
    test_enable_gaps();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bist_multimode_gen.md
Name: bist_multimode_gen

Overview:
- Next-generation BIST stimulus engine. Generates test words in four pattern modes: LFSR, counter, walking-ones and checkerboard.
- Data width, capture-to-data-ready latency, burst length and LFSR taps/seed are parameters.
- Folds every emitted word into an on-chip MISR signature and reports it at burst end, so a checker can compare one word per burst.
- Sits between the test controller (enable/capture_start/mode) and the datapath under test.

Parameters:
DATA_WIDTH, 32, width of data_out and signature (>=8)
C2DR, 3, enabled cycles spent in ARM before first word (0 legal: ARM skipped)
BURST_LEN, 16, words emitted per burst (>=1)
LFSR_TAPS, 32'h0040_0007, Galois feedback taps excluding x^W (x^32+x^22+x^2+x+1); also used by MISR
LFSR_SEED, 32'h0000_0001, LFSR start value; a value of 0 is replaced by 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset (one clock; reset is synchronous and active-high)
enable  input  1  global advance qualifier; low freezes ARM count and RUN stream
capture_start  input  1  request a burst; sampled in IDLE and at burst end
mode  input  2  0=LFSR, 1=counter, 2=walking-ones, 3=checkerboard; latched on entry to ARM
data_out  output  DATA_WIDTH  current test word
valid_out  output  1  data_out is a new word this cycle
sync  output  1  one-cycle pulse coincident with first word of each burst
busy  output  1  high in ARM and RUN
done  output  1  one-cycle pulse the cycle after the last word of a burst
signature  output  DATA_WIDTH  MISR result; stable from done until next burst's first word

Behaviour:
- Reset: all outputs 0, FSM=IDLE, beat counter 0, MISR 0. rst wins over every other input, including mid-burst.
- IDLE: if enable & capture_start at an edge, latch mode and go to ARM (or to RUN directly if C2DR=0). Pattern regs load their start values and the MISR clears to 0.
- ARM: a counter increments only on edges with enable=1. After C2DR such edges, go to RUN.
- Latency: capture_start sampled at edge E0 with enable held high gives the first valid_out=1 after edge E0+C2DR+1.
- RUN, on each edge with enable=1:
  - Emit the current pattern word: valid_out=1, data_out=word.
  - Update the MISR: sig <= (sig<<1) ^ (sig[W-1] ? LFSR_TAPS : 0) ^ word.
  - Advance the pattern and increment the beat count.
- RUN, edge with enable=0: valid_out=0, data_out holds the last word, nothing advances, sync is not reissued.
- sync=1 only together with beat 0.
- After beat BURST_LEN-1:
  - done pulses next cycle; signature is visible the same cycle.
  - If capture_start=1 and enable=1, re-enter ARM with mode relatched and patterns/MISR restarted. Otherwise go to IDLE.
- Start values and step rules:
  - LFSR: start = seed; next = (s<<1) ^ (s[W-1] ? LFSR_TAPS : 0).
  - Counter: start = 0, +1 per word, wraps from all-ones to 0.
  - Walking-ones: start = 1, rotate left, MSB wraps to bit 0.
  - Checkerboard: start = 0x55..55, alternates with 0xAA..AA.
- Changes on mode or capture_start during ARM/RUN are ignored until the burst boundary.
- busy=0 in IDLE and in the done cycle (when returning to IDLE).

Test Plan:
1. Reset mid-RUN: assert rst 2 cycles during beat 2 of a counter burst -> next cycle data_out=0, valid_out=0, sync=0, busy=0, done=0, signature=0. No output until a new capture_start.
2. Counter, C2DR=3, BURST_LEN=4, mode=1, enable=1, capture_start pulsed at E0 -> valid_out high after E0+4..E0+7 with data 0,1,2,3, sync only on word 0. done pulses at E0+8 with signature=0x00000003.
3. LFSR, LFSR_SEED=0x80000000, BURST_LEN=3 -> words 0x80000000, 0x00400007, 0x0080000E. Separately, LFSR_SEED=0 -> first word 0x00000001.
4. Walking-ones wrap, BURST_LEN=34, mode=2 -> word 31 = 0x80000000, word 32 = 0x00000001, word 33 = 0x00000002.
5. Enable gaps: checkerboard burst, drop enable 1 cycle after word 1 and 2 cycles in ARM, toggle mode mid-burst -> ARM stretches by 2 cycles. valid_out=0 with data_out held 0xAAAAAAAA during the gap. Word 2 is 0x55555555. Mode change has no effect; 4 valid words total.
6. Back-to-back bursts: capture_start held high, counter mode, BURST_LEN=4 -> done, then ARM (C2DR cycles), then second burst restarts at 0 with a new sync pulse. Same signature 0x00000003 both bursts.
